comparator4bit_sar_search: RTL and testbench

- Successive-approximation search controller that drives the 4-bit magnitude comparator from the A side.
- Presents guesses on the comparator A input while an unknown target sits on B.
- Reads back A_gt_B / A_lt_B / A_eq_B and binary-searches until equality is found.
- Acts as the initiator/consumer end of the comparator interface; used in the comparator environment as a closed-loop checker and as a reusable SAR core.

---
 rtl/comparator4bit_sar_search.sv | 143 ++++++++++++++
 tb/tb_comparator4bit_sar_search.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/comparator4bit_sar_search.sv
// Successive-approximation search controller driving the A side of a magnitude comparator.
// Optional build macro SAR_FLAG_CHECK_EN: abort the search when comparator flags are not one-hot.
module comparator4bit_sar_search #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned PCW   = $clog2(WIDTH + 2)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             a_gt_b,
    input  logic             a_lt_b,
    input  logic             a_eq_b,
    output logic [WIDTH-1:0] guess,
    output logic             busy,
    output logic             done,
    output logic             found,
    output logic [WIDTH-1:0] result,
    output logic [PCW-1:0]   probes,
    output logic             err
);

    localparam logic [WIDTH-1:0] MAXV = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] MID0 = MAXV >> 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PROBE = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_guess;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_hi;
    logic             r_busy;
    logic             r_done;
    logic             r_found;
    logic [WIDTH-1:0] r_result;
    logic [PCW-1:0]   r_probes;
    logic             r_err;

    logic             w_no_flags;
    logic             w_flag_bad;
    logic             w_take_gt;
    logic             w_take_lt;
    logic             w_range_err;
    logic [WIDTH-1:0] w_next_lo;
    logic [WIDTH-1:0] w_next_hi;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH-1:0] w_next_guess;

    // Flag decode: eq wins over gt, gt over lt, and an all-zero response counts as lt.
    assign w_no_flags = ~(a_gt_b | a_lt_b | a_eq_b);
    assign w_take_gt  = a_gt_b & ~a_eq_b;
    assign w_take_lt  = ~a_eq_b & ~a_gt_b & (a_lt_b | w_no_flags);

`ifdef SAR_FLAG_CHECK_EN
    assign w_flag_bad = ~$onehot({a_gt_b, a_lt_b, a_eq_b});
`else
    assign w_flag_bad = 1'b0;
`endif

    // Narrowing step would leave an empty interval: the target is outside the searchable range.
    assign w_range_err = (w_take_gt & (r_guess == r_lo)) | (w_take_lt & (r_guess == r_hi));

    assign w_next_lo    = w_take_gt ? r_lo : WIDTH'(r_guess + WIDTH'(1));
    assign w_next_hi    = w_take_gt ? WIDTH'(r_guess - WIDTH'(1)) : r_hi;
    assign w_sum        = {1'b0, w_next_lo} + {1'b0, w_next_hi};
    assign w_next_guess = w_sum[WIDTH:1];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_guess  <= '0;
            r_lo     <= '0;
            r_hi     <= MAXV;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_found  <= 1'b0;
            r_result <= '0;
            r_probes <= '0;
            r_err    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_lo     <= '0;
                        r_hi     <= MAXV;
                        r_guess  <= MID0;
                        r_probes <= '0;
                        r_found  <= 1'b0;
                        r_err    <= 1'b0;
                        r_result <= '0;
                        r_busy   <= 1'b1;
                        r_state  <= ST_PROBE;
                    end
                end
                ST_PROBE: begin
                    r_probes <= PCW'(r_probes + PCW'(1));
                    if (w_flag_bad) begin
                        r_err   <= 1'b1;
                        r_found <= 1'b0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= ST_DONE;
                    end else if (a_eq_b) begin
                        r_result <= r_guess;
                        r_found  <= 1'b1;
                        r_busy   <= 1'b0;
                        r_done   <= 1'b1;
                        r_state  <= ST_DONE;
                    end else if (w_range_err) begin
                        r_err   <= 1'b1;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= ST_DONE;
                    end else begin
                        r_lo    <= w_next_lo;
                        r_hi    <= w_next_hi;
                        r_guess <= w_next_guess;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign guess  = r_guess;
    assign busy   = r_busy;
    assign done   = r_done;
    assign found  = r_found;
    assign result = r_result;
    assign probes = r_probes;
    assign err    = r_err;

endmodule

// File: tb/tb_comparator4bit_sar_search.sv
// Directed bench for comparator4bit_sar_search: closed-loop comparator model with flag override.
module tb_comparator4bit_sar_search;

    logic       clk;
    logic       rst;
    logic       start;
    logic       a_gt_b;
    logic       a_lt_b;
    logic       a_eq_b;
    logic [3:0] guess;
    logic       busy;
    logic       done;
    logic       found;
    logic [3:0] result;
    logic [2:0] probes;
    logic       err;

    logic [3:0] target;
    logic       force_en;
    logic [2:0] force_flags;
    int         checks;
    int         errors;
    int         cyc;

    comparator4bit_sar_search dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .a_gt_b (a_gt_b),
        .a_lt_b (a_lt_b),
        .a_eq_b (a_eq_b),
        .guess  (guess),
        .busy   (busy),
        .done   (done),
        .found  (found),
        .result (result),
        .probes (probes),
        .err    (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Ideal combinational comparator with B = target; force_flags = {gt, lt, eq}.
    assign a_gt_b = force_en ? force_flags[2] : (guess > target);
    assign a_lt_b = force_en ? force_flags[1] : (guess < target);
    assign a_eq_b = force_en ? force_flags[0] : (guess == target);

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference binary search count for target b over 0..15.
    function automatic int model_probes(input int b);
        int lo = 0;
        int hi = 15;
        int n = 0;
        int g;
        for (int k = 0; k < 8; k++) begin
            g = (lo + hi) / 2;
            n++;
            if (g == b) return n;
            if (g > b) hi = g - 1;
            else lo = g + 1;
        end
        return -1;
    endfunction

    // Runs a consistent search, checking every guess given in gseq (first guess in the top nibble).
    task automatic run_search(input string tag, input logic [3:0] tgt, input int n,
                              input logic [19:0] gseq);
        target = tgt;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        for (int i = 0; i < n; i++) begin
            chk({tag, "_guess"}, 32'(guess), 32'(gseq[19-4*i -: 4]));
            chk({tag, "_busy"}, 32'(busy), 32'd1);
            tick();
        end
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_found"}, 32'(found), 32'd1);
        chk({tag, "_result"}, 32'(result), 32'(tgt));
        chk({tag, "_probes"}, 32'(probes), 32'(n));
        chk({tag, "_err"}, 32'(err), 32'd0);
        chk({tag, "_busy_off"}, 32'(busy), 32'd0);
        tick();
        chk({tag, "_done_pulse"}, 32'(done), 32'd0);
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        rst         = 1'b1;
        start       = 1'b0;
        target      = 4'd0;
        force_en    = 1'b0;
        force_flags = 3'b000;
        tick();
        tick();
        chk("rst_guess", 32'(guess), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_found", 32'(found), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_probes", 32'(probes), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        rst = 1'b0;
        tick();
        chk("idle_hold_busy", 32'(busy), 32'd0);

        run_search("b7", 4'd7, 1, {4'd7, 16'h0});
        run_search("b0", 4'd0, 4, {4'd7, 4'd3, 4'd1, 4'd0, 4'd0});
        run_search("b15", 4'd15, 5, {4'd7, 4'd11, 4'd13, 4'd14, 4'd15});

        // Back-to-back sweep; start is raised during the DONE cycle and held into IDLE.
        target = 4'd0;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        for (int b = 0; b < 16; b++) begin
            cyc = 0;
            while (done !== 1'b1 && cyc < 8) begin
                tick();
                cyc++;
            end
            chk("sweep_timeout", 32'(done), 32'd1);
            chk("sweep_found", 32'(found), 32'd1);
            chk("sweep_result", 32'(result), 32'(b));
            chk("sweep_probes", 32'(probes), 32'(model_probes(b)));
            chk("sweep_probes_le5", 32'(probes <= 3'd5), 32'd1);
            chk("sweep_latency", 32'(cyc), 32'(model_probes(b)));
            if (b < 15) start = 1'b1;
            tick();
            chk("sweep_done_width", 32'(done), 32'd0);
            chk("sweep_idle_busy", 32'(busy), 32'd0);
            if (b < 15) begin
                target = 4'(b + 1);
                tick();
                start = 1'b0;
            end
        end

        // Reset in the middle of a search aborts with no done pulse.
        target = 4'd9;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        chk("rstmid_g0", 32'(guess), 32'd7);
        tick();
        chk("rstmid_g1", 32'(guess), 32'd11);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rstmid_guess", 32'(guess), 32'd0);
        chk("rstmid_busy", 32'(busy), 32'd0);
        chk("rstmid_done", 32'(done), 32'd0);
        chk("rstmid_found", 32'(found), 32'd0);
        chk("rstmid_probes", 32'(probes), 32'd0);
        chk("rstmid_err", 32'(err), 32'd0);
        tick();
        chk("rstmid_no_done", 32'(done), 32'd0);
        chk("rstmid_idle", 32'(busy), 32'd0);

        // Start pulsed while busy must not disturb the 7, 11, 9 sequence.
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("sbusy_g0", 32'(guess), 32'd7);
        tick();
        start = 1'b1;
        chk("sbusy_g1", 32'(guess), 32'd11);
        tick();
        start = 1'b0;
        chk("sbusy_g2", 32'(guess), 32'd9);
        tick();
        chk("sbusy_done", 32'(done), 32'd1);
        chk("sbusy_result", 32'(result), 32'd9);
        chk("sbusy_probes", 32'(probes), 32'd3);
        tick();

        // All-zero flags on the first probe.
        force_en    = 1'b1;
        force_flags = 3'b000;
        start       = 1'b1;
        tick();
        start       = 1'b0;
        chk("zf_g0", 32'(guess), 32'd7);
        tick();
`ifdef SAR_FLAG_CHECK_EN
        chk("zf_done", 32'(done), 32'd1);
        chk("zf_err", 32'(err), 32'd1);
        chk("zf_found", 32'(found), 32'd0);
        chk("zf_probes", 32'(probes), 32'd1);
`else
        chk("zf_guess_lt", 32'(guess), 32'd11);
        chk("zf_busy", 32'(busy), 32'd1);
        chk("zf_probes", 32'(probes), 32'd1);
        chk("zf_err", 32'(err), 32'd0);
`endif
        force_en = 1'b0;
        rst      = 1'b1;
        tick();
        rst      = 1'b0;
        tick();

        // gt reported at guess 0 with lo 0 exhausts the range.
        target = 4'd0;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        chk("gt0_g0", 32'(guess), 32'd7);
        tick();
        chk("gt0_g1", 32'(guess), 32'd3);
        tick();
        chk("gt0_g2", 32'(guess), 32'd1);
        tick();
        chk("gt0_g3", 32'(guess), 32'd0);
        force_en    = 1'b1;
        force_flags = 3'b100;
        tick();
        force_en    = 1'b0;
        chk("gt0_done", 32'(done), 32'd1);
        chk("gt0_err", 32'(err), 32'd1);
        chk("gt0_found", 32'(found), 32'd0);
        chk("gt0_probes", 32'(probes), 32'd4);
        tick();
        chk("gt0_err_hold", 32'(err), 32'd1);
        chk("gt0_done_pulse", 32'(done), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
